// File: rtl/jk_pkg.sv
// Shared types, mode constants and the J/K excitation rule for jk_excitation_gen.
package jk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MODE_SRRH   = 0;
  localparam int MODE_TOGGLE = 1;

  // Returns {j,k} that moves a jk_ff from q to b under the selected policy.
  function automatic logic [1:0] jk_excite(input logic b, input logic q, input int mode);
    logic [1:0] jk;
    jk = 2'b00;
    if (mode == MODE_TOGGLE) begin
      jk = (b != q) ? 2'b11 : 2'b00;
    end else begin
      if (b == q)  jk = 2'b00;
      else if (b)  jk = 2'b10;
      else         jk = 2'b01;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_ff_checker.sv
// Two-stage expectation pipeline that lines each issued bit up with the q
// returned by the downstream jk_ff, flags mismatches and counts them.
module jk_ff_checker
  import jk_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             exp_bit,
  input  logic             q_fb,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  logic stage1_bit;
  logic stage1_vld;
  logic stage2_bit;
  logic stage2_vld;

  // Delay expectations by two edges, then compare with q_fb and count misses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage1_bit <= 1'b0;
      stage1_vld <= 1'b0;
      stage2_bit <= 1'b0;
      stage2_vld <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      stage1_bit <= exp_bit;
      stage1_vld <= issue;
      stage2_bit <= stage1_bit;
      stage2_vld <= stage1_vld;
      if (stage2_vld && (q_fb != stage2_bit)) begin
        err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/jk_excitation_gen.sv
// Replays a WIDTH-bit target pattern LSB-first onto a jk_ff through registered
// J/K drive, and checks the flip-flop's q against an internal model.
module jk_excitation_gen
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             model_q;
  logic             bit_cur;
  logic             last_bit;
  logic             pre_last;
  logic             issue;
  logic [1:0]       jk_next;

  // Current bit, position flags and the excitation it needs from model_q.
  always_comb begin
    bit_cur  = shreg[idx];
    last_bit = (idx == IDX_W'(WIDTH - 1));
    pre_last = (idx == IDX_W'(WIDTH - 2));
    issue    = (state == SHIFT);
    jk_next  = jk_excite(bit_cur, model_q, MODE);
  end

  // Sequencer: accept pattern, issue one bit per edge, stream the next word
  // on the last-bit edge; in_ready is registered one edge early so it is
  // already high during the last SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      model_q  <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          j        <= 1'b0;
          k        <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            idx      <= '0;
            state    <= SHIFT;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          j        <= jk_next[1];
          k        <= jk_next[0];
          model_q  <= bit_cur;
          idx      <= idx + IDX_W'(1);
          in_ready <= pre_last;
          if (last_bit) begin
            done <= 1'b1;
            if (in_valid && in_ready) begin
              shreg    <= in_data;
              idx      <= '0;
              in_ready <= 1'b0;
            end else begin
              state    <= IDLE;
              idx      <= '0;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  jk_ff_checker #(
    .ERR_W(ERR_W)
  ) u_checker (
    .clk    (clk),
    .rst    (rst),
    .issue  (issue),
    .exp_bit(bit_cur),
    .q_fb   (q_fb),
    .err    (err),
    .err_cnt(err_cnt)
  );

endmodule

// File: doc/jk_excitation_gen.md
Name: jk_excitation_gen

Overview:
Sequential driver for the team's jk_ff flip-flop. It accepts a WIDTH-bit target pattern over a valid/ready handshake and emits per-cycle J/K excitation so the downstream jk_ff's q replays the pattern LSB-first. It keeps an internal model of q and checks the q fed back from the flip-flop, counting mismatches. It replaces random-stimulus bring-up with a deterministic, self-checking hardware source.

Parameters:
WIDTH, 8, pattern length in bits (2..32)
MODE, 0, excitation policy: 0 = set/reset/hold, 1 = toggle/hold
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low
in_valid  input  1  pattern offered
in_ready  output  1  block can accept a pattern
in_data  input  WIDTH  target q pattern, bit 0 replayed first
j  output  1  J drive to jk_ff (registered)
k  output  1  K drive to jk_ff (registered)
q_fb  input  1  q returned from the driven jk_ff
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse after last bit's j/k is issued
err  output  1  sticky mismatch flag
err_cnt  output  ERR_W  saturating mismatch count

Behaviour:
- Reset: one clock; synchronous, active-low. Port names are clk and rst. While rst=0 at a rising edge: state=IDLE, j=0, k=0, in_ready=0, busy=0, done=0, err=0, err_cnt=0, model_q=0, check pipeline cleared. in_ready rises the cycle after rst deasserts.
- model_q reset value 0 matches the jk_ff reset value. Both blocks must share rst.
- States: IDLE, SHIFT.
- IDLE: in_ready=1, j=k=0. Transfer at an edge with in_valid&in_ready: capture in_data into shreg, idx=0, go SHIFT.
- SHIFT: each edge drives j/k for bit b=shreg[idx], sets model_q<=b, idx<=idx+1.
  - On the edge issuing idx=WIDTH-1: done<=1. If in_valid, load the next pattern and stay in SHIFT (in_ready=1 in that last cycle, so streaming has no bubble). Otherwise go IDLE.
- MODE 0 excitation: b==model_q gives (0,0); b=1, model_q=0 gives (1,0); b=0, model_q=1 gives (0,1).
- MODE 1 excitation: b!=model_q gives (1,1); otherwise (0,0).
- In IDLE, j=k=0 so q holds its last value.
- Timing: pattern captured at edge E0. j/k for bit i are valid after edge E(i+1). jk_ff q shows bit i after E(i+2). Check compares q_fb at E(i+3).
- Check pipeline: 2-stage exp_bit/exp_vld shift register loaded alongside j/k.
  - At each edge with exp_vld at stage 2 and q_fb!=exp_bit: err<=1, err_cnt<=err_cnt+1, saturating at all-ones.
  - Stages drain normally after return to IDLE. No check occurs while exp_vld=0.
- err and err_cnt clear only on reset.
- Reset mid-SHIFT: pattern is discarded, outputs go to reset values, and no done pulse is issued.
- in_valid while in SHIFT (not last cycle) is ignored. The source must hold in_valid until ready.

Decomposition:
- Package jk_pkg: state enum (IDLE, SHIFT), MODE_SRRH=0, MODE_TOGGLE=1 constants, and function jk_excite(b, q, mode) returning {j,k}.
- Sub-module jk_ff_checker holds the 2-stage expectation pipeline, comparator, sticky err and saturating counter.
- The top module holds the FSM, shift register and excitation logic.

Test Plan:
- MODE0, WIDTH=8, in_data=8'hB2 (bits 0,1,0,0,1,1,0,1), real jk_ff on q_fb -> j/k sequence (0,0),(1,0),(0,1),(0,0),(1,0),(0,0),(0,1),(1,0); q replays 0,1,0,0,1,1,0,1; done one pulse; err=0.
- MODE1, same pattern -> j/k (0,0),(1,1),(1,1),(0,0),(1,1),(0,0),(1,1),(1,1); q identical; err=0.
- Back-to-back: 8'hFF then 8'h00 with in_valid held -> no idle cycle between them; j/k after first bit of second word = (0,1) in MODE0; two done pulses 8 cycles apart.
- Fault: q_fb forced 0, pattern 8'hFF -> err=1 from cycle 3; err_cnt=8 after drain; then with ERR_W=2 -> err_cnt saturates at 3.
- Reset mid-SHIFT (rst=0 at bit 3) -> next edge j=k=0, busy=0, done never pulses, err_cnt=0; in_ready=1 the cycle after rst=1.
- in_valid asserted in a non-last SHIFT cycle -> ignored; pattern accepted only at the last bit or in IDLE.
